// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-master data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  // Misaligned byte address, or word index beyond the memory.
  function automatic logic word_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port != last.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  assign gnt[PORT0] = req[PORT0] & (~req[PORT1] | last);
  assign gnt[PORT1] = req[PORT1] & (~req[PORT0] | ~last);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU LSU (port 0) and the DMA/debug
// loader (port 1), with locked bursts capped by a fairness limit and 1-cycle responses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int CW = $clog2(MAX_BURST);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_t    state_q;
  logic          last_q;
  logic [CW-1:0] beat_cnt_q;

  logic [1:0] req, rr_gnt, gnt;
  logic       gnt_any, sel, sel_we, sel_lock, other_req;
  logic       err_c, owner_beat, final_beat;

  assign req = {m1_req, m0_req};

  rr_arb2 u_rr (
    .req  (req),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  // The owner keeps the memory while it requests; otherwise fall back to round-robin.
  always_comb begin
    gnt = 2'b00;
    if (reset_n) begin
      case (state_q)
        ARB_OWN0: gnt = m0_req ? 2'b01 : rr_gnt;
        ARB_OWN1: gnt = m1_req ? 2'b10 : rr_gnt;
        default:  gnt = rr_gnt;
      endcase
    end
  end

  assign gnt_any   = |gnt;
  assign sel       = gnt[PORT1];
  assign sel_we    = gnt_any & (sel ? m1_we : m0_we);
  assign sel_lock  = sel ? m1_lock : m0_lock;
  assign other_req = sel ? m0_req : m1_req;

  assign mem_a  = gnt_any ? (sel ? m1_addr : m0_addr) : '0;
  assign mem_wd = gnt_any ? (sel ? m1_wdata : m0_wdata) : '0;
  assign err_c  = word_err(mem_a, DEPTH);
  assign mem_we = sel_we & ~err_c;

  assign owner_beat = ((state_q == ARB_OWN0) & ~sel) | ((state_q == ARB_OWN1) & sel);
  assign final_beat = (beat_cnt_q == LAST_BEAT) & other_req;

  assign m0_gnt = gnt[PORT0];
  assign m1_gnt = gnt[PORT1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      last_q     <= 1'b1;
      beat_cnt_q <= '0;
    end else if (gnt_any) begin
      last_q <= sel;
      if (owner_beat && !final_beat && sel_lock) begin
        state_q <= state_q;
        if (beat_cnt_q != LAST_BEAT) beat_cnt_q <= beat_cnt_q + 1'b1;
      end else if (!owner_beat && sel_lock) begin
        state_q    <= sel ? ARB_OWN1 : ARB_OWN0;
        beat_cnt_q <= CW'(1);
      end else begin
        state_q    <= ARB_IDLE;
        beat_cnt_q <= '0;
      end
    end else begin
      state_q    <= ARB_IDLE;
      beat_cnt_q <= '0;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    logic        rvalid_q;
    logic        err_q;
    logic [31:0] rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rvalid_q <= 1'b0;
        err_q    <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= gnt[gi];
        err_q    <= gnt[gi] & err_c;
        rdata_q  <= (gnt[gi] & ~sel_we & ~err_c) ? mem_rd : '0;
      end
    end
  end

  assign m0_rvalid = g_rsp[0].rvalid_q;
  assign m0_err    = g_rsp[0].err_q;
  assign m0_rdata  = g_rsp[0].rdata_q;
  assign m1_rvalid = g_rsp[1].rvalid_q;
  assign m1_err    = g_rsp[1].err_q;
  assign m1_rdata  = g_rsp[1].rdata_q;

endmodule
